// File: rtl/md_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one md_process datapath.
// A grant is held from arbitration until the granted packet's tlast beat is accepted.
module md_stream_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int PORT_W               = $clog2(NUM_PORTS)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                          s_axis_tready,
  input  logic [NUM_PORTS-1:0]                          s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic [PORT_W-1:0]                             grant_idx,
  output logic                                          busy,
  output logic [31:0]                                   pkt_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [DW-1:0] data_a [NUM_PORTS];
  logic [KW-1:0] keep_a [NUM_PORTS];
  logic [UW-1:0] user_a [NUM_PORTS];

  logic              win_vld;
  logic [PORT_W-1:0] win_idx;
  logic              eop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign data_a[i] = s_axis_tdata[i*DW +: DW];
    assign keep_a[i] = s_axis_tkeep[i*KW +: KW];
    assign user_a[i] = s_axis_tuser[i*UW +: UW];
  end

  // Rotating search from rr_ptr; scanning downward lets the lowest offset win.
  always_comb begin
    int p;
    logic [PORT_W-1:0] pi;
    p       = 0;
    pi      = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      p = int'(rr_ptr_q) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      pi = PORT_W'(p);
      if (s_axis_tvalid[pi]) begin
        win_vld = 1'b1;
        win_idx = pi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  assign eop = (state_q == BUSY) && m_axis_tvalid &&
               m_axis_tready && m_axis_tlast;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          grant_d = win_idx;
        end
      end
      BUSY: begin
        if (eop) begin
          state_d  = IDLE;
          cnt_d    = cnt_q + 32'd1;
          // Explicit compare so non-power-of-two port counts wrap correctly.
          rr_ptr_d = (grant_q == LAST_PORT) ? '0
                                            : grant_q + PORT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      m_axis_tdata           = data_a[grant_q];
      m_axis_tkeep           = keep_a[grant_q];
      m_axis_tuser           = user_a[grant_q];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_md_stream_arbiter.sv
// Bench for md_stream_arbiter: directed vector table, corner sequences,
// then random traffic against a packet-level reference model.
module tb_md_stream_arbiter;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int N  = 4;
  localparam int PW = 2;

  logic clk;
  logic rst;
  logic [DW-1:0] pd [N];
  logic [KW-1:0] pk [N];
  logic [UW-1:0] pu [N];
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [PW-1:0]   grant_idx;
  logic            busy;
  logic [31:0]     pkt_count;

  int total;
  int bad;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_tdata[i*DW +: DW] = pd[i];
    assign s_tkeep[i*KW +: KW] = pk[i];
    assign s_tuser[i*UW +: UW] = pu[i];
  end

  md_stream_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS           (N),
    .PORT_W              (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int p);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'hC0DE0000 + p;
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rnd_user();
    logic [UW-1:0] u;
    for (int k = 0; k < UW / 32; k++) u[k*32 +: 32] = $urandom;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        mr;
    logic        e_mv;
    logic [3:0]  e_tr;
    logic        e_busy;
    logic [1:0]  e_g;
    logic [31:0] e_cnt;
    logic        e_last;
  } vec_t;

  vec_t tbl [13];

  // reference model state
  int          m_lock;
  int          m_ptr;
  int          m_g;
  logic [31:0] m_cnt;
  int          rem [N];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    m_tready = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < N; i++) begin
      pd[i] = pat(i);
      pk[i] = '1;
      pu[i] = UW'(32'hBEEF0000 + i);
    end

    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd0, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd0, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd0, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 32'd1, 1'b0};
    tbl[6]  = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 32'd1, 1'b0};
    tbl[7]  = '{4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'd1, 1'b0};
    tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd1, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd1, 1'b1};
    tbl[10] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd2, 1'b0};
    tbl[11] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 32'd3, 1'b0};

    // reset / idle
    tick();
    tick();
    @(negedge clk);
    check("rst_mvalid", 256'(m_tvalid), 256'(1'b0));
    check("rst_tready", 256'(s_tready), 256'(4'b0000));
    check("rst_busy",   256'(busy),     256'(1'b0));
    check("rst_cnt",    256'(pkt_count), 256'(32'd0));
    check("rst_grant",  256'(grant_idx), 256'(2'd0));
    rst = 1'b0;
    tick();

    // directed vector table
    for (int r = 0; r < 13; r++) begin
      s_tvalid = tbl[r].v;
      s_tlast  = tbl[r].l;
      m_tready = tbl[r].mr;
      @(negedge clk);
      check($sformatf("tbl%0d_mvalid", r), 256'(m_tvalid), 256'(tbl[r].e_mv));
      check($sformatf("tbl%0d_tready", r), 256'(s_tready), 256'(tbl[r].e_tr));
      check($sformatf("tbl%0d_busy", r),   256'(busy),     256'(tbl[r].e_busy));
      check($sformatf("tbl%0d_grant", r),  256'(grant_idx), 256'(tbl[r].e_g));
      check($sformatf("tbl%0d_cnt", r),    256'(pkt_count), 256'(tbl[r].e_cnt));
      if (tbl[r].e_mv) begin
        check($sformatf("tbl%0d_last", r), 256'(m_tlast), 256'(tbl[r].e_last));
        check($sformatf("tbl%0d_data", r), m_tdata, pat(int'(tbl[r].e_g)));
      end
      tick();
    end

    // reset mid-packet: rr_ptr=2 so port 3 wins over port 1
    s_tvalid = 4'b1010;
    s_tlast  = 4'b0000;
    m_tready = 1'b1;
    tick();
    @(negedge clk);
    check("mid_grant", 256'(grant_idx), 256'(2'd3));
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_busy",   256'(busy),      256'(1'b0));
    check("mid_tready", 256'(s_tready),  256'(4'b0000));
    check("mid_mvalid", 256'(m_tvalid),  256'(1'b0));
    check("mid_cnt",    256'(pkt_count), 256'(32'd0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("mid_regrant", 256'(grant_idx), 256'(2'd1));
    check("mid_retready", 256'(s_tready), 256'(4'b0010));

    // fairness: all ports stream single-beat packets
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    m_tready = 1'b1;
    begin
      int beats;
      beats = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (m_tvalid) begin
          check($sformatf("rr_grant%0d", beats), 256'(grant_idx),
                256'(beats % N));
          check($sformatf("rr_data%0d", beats), m_tdata, pat(beats % N));
          beats++;
        end
        tick();
      end
      @(negedge clk);
      check("rr_beats", 256'(beats), 256'(8));
      check("rr_cnt", 256'(pkt_count), 256'(32'd8));
    end

    // random traffic against the packet-level model
    s_tvalid = '0;
    s_tlast  = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lock = -1;
    m_ptr  = 0;
    m_g    = 0;
    m_cnt  = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] hs;
      logic [3:0]   e_tr;
      logic         e_mv;
      m_tready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      e_tr = '0;
      e_mv = 1'b0;
      hs   = '0;
      if (m_lock >= 0) begin
        e_mv = s_tvalid[m_lock];
        e_tr[m_lock] = m_tready;
        hs[m_lock] = s_tvalid[m_lock] & m_tready;
      end
      check("rnd_mvalid", 256'(m_tvalid), 256'(e_mv));
      check("rnd_tready", 256'(s_tready), 256'(e_tr));
      check("rnd_busy",   256'(busy),     256'(m_lock >= 0));
      check("rnd_grant",  256'(grant_idx), 256'(m_g));
      check("rnd_cnt",    256'(pkt_count), 256'(m_cnt));
      if (e_mv) begin
        check("rnd_data", m_tdata, pd[m_lock]);
        check("rnd_keep", 256'(m_tkeep), 256'(pk[m_lock]));
        check("rnd_user", 256'(m_tuser), 256'(pu[m_lock]));
        check("rnd_last", 256'(m_tlast), 256'(s_tlast[m_lock]));
      end
      if (rst) begin
        m_lock = -1;
        m_ptr  = 0;
        m_g    = 0;
        m_cnt  = '0;
      end else if (m_lock < 0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (s_tvalid[(m_ptr + k) % N]) m_lock = (m_ptr + k) % N;
        end
        if (m_lock >= 0) m_g = m_lock;
      end else if (hs[m_lock] && s_tlast[m_lock]) begin
        m_ptr  = (m_lock + 1) % N;
        m_cnt  = m_cnt + 32'd1;
        m_lock = -1;
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          rem[i]--;
          s_tvalid[i] = 1'b0;
        end
        if (!s_tvalid[i]) begin
          if (rem[i] == 0 && $urandom_range(0, 3) == 0)
            rem[i] = $urandom_range(1, 4);
          if (rem[i] > 0 && $urandom_range(0, 1) == 1) begin
            s_tvalid[i] = 1'b1;
            s_tlast[i]  = (rem[i] == 1);
            pd[i] = rnd_data();
            pk[i] = KW'({$urandom, $urandom});
            pu[i] = rnd_user();
          end
        end
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
